// File: rtl/booth_r4_seq_mult.sv
// booth_r4_seq_mult: sequential radix-4 Booth multiplier, one digit/clock.
// Optional BOOTH_R4_EARLY_TERM_EN: finish once remaining digits are zero.
module booth_r4_seq_mult #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
  output logic               ready,
  output logic               valid,
  output logic [2*WIDTH-1:0] product
);

  localparam int EW = WIDTH + 2;
  localparam int D  = EW / 2;
  localparam int PW = 2 * WIDTH;
  localparam int KW = $clog2(D);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  // A extended to PW bits; shifted left by 2 per digit so it is A<<2k.
  logic [PW-1:0] a_q, a_d;
  // {extended B, B[-1]}; shifted right by 2 per digit, triplet in [2:0].
  logic [EW:0]   b_q, b_d;
  logic [PW-1:0] acc_q, acc_d;
  logic [PW-1:0] prod_q, prod_d;
  logic [KW-1:0] k_q, k_d;
  logic          valid_q, valid_d;

  logic [PW-1:0] pp;
  logic [EW:0]   b_sh;
  logic          last;

  // Remaining multiplier bits after retiring this digit, sign-filled.
  assign b_sh = {b_q[EW], b_q[EW], b_q[EW:2]};

`ifdef BOOTH_R4_EARLY_TERM_EN
  // Stop when every remaining digit must decode to zero.
  assign last = (k_q == KW'(D - 1)) || (&b_sh) || ~(|b_sh);
`else
  assign last = (k_q == KW'(D - 1));
`endif

  // Booth digit decode into the shifted partial product.
  always_comb begin
    pp = '0;
    case (b_q[2:0])
      3'b001, 3'b010: pp = a_q;
      3'b011:         pp = a_q << 1;
      3'b100:         pp = -(a_q << 1);
      3'b101, 3'b110: pp = -a_q;
      default:        pp = '0;
    endcase
  end

  // Next-state logic for the control FSM and datapath registers.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    prod_d  = prod_q;
    k_d     = k_q;
    valid_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          a_d = {{WIDTH{signed_mode & a_in[WIDTH-1]}}, a_in};
          b_d = {{2{signed_mode & b_in[WIDTH-1]}}, b_in, 1'b0};
          acc_d = '0;
          k_d = '0;
        end
      end
      S_RUN: begin
        acc_d = acc_q + pp;
        a_d = a_q << 2;
        b_d = b_sh;
        k_d = k_q + KW'(1);
        if (last) begin
          prod_d  = acc_q + pp;
          valid_d = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      prod_q  <= '0;
      k_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      prod_q  <= prod_d;
      k_q     <= k_d;
      valid_q <= valid_d;
    end
  end

  assign ready   = (state_q == S_IDLE);
  assign valid   = valid_q;
  assign product = prod_q;

endmodule

// File: tb/tb_booth_r4_seq_mult.sv
// tb_booth_r4_seq_mult: directed + random bench for booth_r4_seq_mult.
// Instances at WIDTH 32, 8 and 16 share one scoreboard monitor.
module tb_booth_r4_seq_mult;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_s = 1'b1;
  logic [2:0] st = '0;
  logic [2:0] sm = '0;
  logic [63:0] av [3];
  logic [63:0] bv [3];
  wire  [2:0] rdy;
  wire  [2:0] vld;
  wire  [63:0] p32;
  wire  [15:0] p8;
  wire  [31:0] p16;
  logic [63:0] pr [3];
  logic [63:0] q [3][$];
  logic [63:0] last_p [3];
  int ws [3] = '{32, 8, 16};
  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  booth_r4_seq_mult #(.WIDTH(32)) u32 (
    .clk(clk), .rst(rst), .start(st[0]), .signed_mode(sm[0]),
    .a_in(av[0][31:0]), .b_in(bv[0][31:0]),
    .ready(rdy[0]), .valid(vld[0]), .product(p32));

  booth_r4_seq_mult #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst_s), .start(st[1]), .signed_mode(sm[1]),
    .a_in(av[1][7:0]), .b_in(bv[1][7:0]),
    .ready(rdy[1]), .valid(vld[1]), .product(p8));

  booth_r4_seq_mult #(.WIDTH(16)) u16 (
    .clk(clk), .rst(rst_s), .start(st[2]), .signed_mode(sm[2]),
    .a_in(av[2][15:0]), .b_in(bv[2][15:0]),
    .ready(rdy[2]), .valid(vld[2]), .product(p16));

  always_comb begin
    pr[0] = p32;
    pr[1] = {48'b0, p8};
    pr[2] = {32'b0, p16};
  end

  // Reference: extend per mode, multiply, keep 2*w bits.
  function automatic logic [63:0] model(input logic [63:0] a,
                                        input logic [63:0] b,
                                        input logic m, input int w);
    logic [63:0] msk, ae, be, p;
    msk = (64'd1 << w) - 64'd1;
    ae = a & msk;
    be = b & msk;
    if (m && a[w-1]) ae = ae | ~msk;
    if (m && b[w-1]) be = be | ~msk;
    p = ae * be;
    if (2 * w < 64) p = p & ((64'd1 << (2 * w)) - 64'd1);
    return p;
  endfunction

  task automatic chk(input string name, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Scoreboard: queue expected products at accept, check every cycle.
  initial begin
    for (int i = 0; i < 3; i++) begin
      last_p[i] = '0;
      av[i] = '0;
      bv[i] = '0;
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      logic r;
      r = (i == 0) ? rst : rst_s;
      if (vld[i]) begin
        checks++;
        if (q[i].size() == 0) begin
          errs++;
          $display("FAIL extra_valid w=%0d got=%h exp=none",
                   ws[i], pr[i]);
        end else begin
          last_p[i] = q[i].pop_front();
          chk($sformatf("product w=%0d", ws[i]), pr[i], last_p[i]);
        end
      end else begin
        chk($sformatf("hold w=%0d", ws[i]), pr[i], last_p[i]);
      end
      if (r) begin
        q[i].delete();
        last_p[i] = '0;
      end else if (st[i] && rdy[i]) begin
        q[i].push_back(model(av[i], bv[i], sm[i], ws[i]));
      end
    end
  end

  // Wait for valid on the 32-bit instance, counting edges after accept.
  task automatic wait_valid(output int lat);
    int g;
    lat = 0;
    for (g = 0; g < 40; g++) begin
      @(negedge clk);
      if (vld[0]) break;
      @(posedge clk);
      lat++;
    end
    if (!vld[0]) begin
      checks++;
      errs++;
      $display("FAIL valid_timeout got=0 exp=1");
    end
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input logic m, output int lat);
    int g;
    @(posedge clk); #1;
    for (g = 0; g < 50 && !rdy[0]; g++) begin
      @(posedge clk); #1;
    end
    st[0] = 1'b1;
    av[0] = {32'b0, a};
    bv[0] = {32'b0, b};
    sm[0] = m;
    @(posedge clk); #1;
    st[0] = 1'b0;
    wait_valid(lat);
  endtask

  initial begin
    int lat;
    int g;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", {63'b0, rdy[0]}, 64'd1);
    chk("reset_valid", {63'b0, vld[0]}, 64'd0);
    chk("reset_product", p32, 64'd0);
    rst = 1'b0;
    rst_s = 1'b0;

    chk("model_pin_ext",
        model(64'h7FFFFFFF, 64'h80000000, 1'b1, 32),
        64'hC000000080000000);
    chk("model_pin_w8", model(64'h80, 64'hFF, 1'b1, 8), 64'h0080);

    issue(32'h7FFFFFFF, 32'h80000000, 1'b1, lat);
    chk("signed_extreme", p32, 64'hC000000080000000);
`ifndef BOOTH_R4_EARLY_TERM_EN
    chk("latency_D", 64'(lat), 64'd17);
`endif
    issue(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, lat);
    chk("ones_signed", p32, 64'h0000000000000001);
    issue(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, lat);
    chk("ones_unsigned", p32, 64'hFFFFFFFE00000001);

    // Start pulse while busy must be dropped.
    @(posedge clk); #1;
    st[0] = 1'b1; av[0] = 64'd3; bv[0] = 64'd7; sm[0] = 1'b1;
    @(posedge clk); #1;
    st[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("busy_ready", {63'b0, rdy[0]}, 64'd0);
    st[0] = 1'b1; av[0] = 64'd9; bv[0] = 64'd9;
    wait_valid(lat);
    chk("busy_product", p32, 64'd21);
    @(posedge clk); #1;
    chk("idle_ready", {63'b0, rdy[0]}, 64'd1);
    @(posedge clk); #1;
    st[0] = 1'b0;
    chk("held_accepted", {63'b0, rdy[0]}, 64'd0);
    wait_valid(lat);
    chk("held_product", p32, 64'd81);

    // Reset on edge 8 of RUN.
    @(posedge clk); #1;
    st[0] = 1'b1; av[0] = 64'h12345678; bv[0] = 64'h9ABCDEF0;
    @(posedge clk); #1;
    st[0] = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_ready", {63'b0, rdy[0]}, 64'd1);
    chk("midrst_valid", {63'b0, vld[0]}, 64'd0);
    chk("midrst_product", p32, 64'd0);
    issue(32'hFFFFFFFE, 32'd5, 1'b1, lat);
    chk("after_rst", p32, 64'hFFFFFFFFFFFFFFF6);

    issue(32'd5, 32'd3, 1'b0, lat);
    chk("small_unsigned", p32, 64'd15);
`ifdef BOOTH_R4_EARLY_TERM_EN
    chk("early_lat2", 64'(lat), 64'd2);
`endif
    issue(32'h1234, 32'hFFFFFFFF, 1'b1, lat);
    chk("neg_one", p32, 64'hFFFFFFFFFFFFEDCC);
`ifdef BOOTH_R4_EARLY_TERM_EN
    chk("early_lat1", 64'(lat), 64'd1);
`endif

    // Random back-to-back traffic on the narrow instances.
    for (int n = 0; n < 400; n++) begin
      @(posedge clk); #1;
      for (int j = 1; j < 3; j++) begin
        st[j] = ($urandom_range(0, 3) != 0);
        sm[j] = 1'($urandom_range(0, 1));
        av[j] = {$urandom, $urandom};
        bv[j] = {$urandom, $urandom};
        if ($urandom_range(0, 7) == 0) av[j] = (j == 1) ? 64'h80 : 64'h8000;
        if ($urandom_range(0, 7) == 0) bv[j] = '1;
      end
    end
    @(posedge clk); #1;
    st[1] = 1'b0;
    st[2] = 1'b0;
    for (g = 0; g < 100 && (q[1].size() != 0 || q[2].size() != 0); g++)
      @(posedge clk);
    chk("drain", 64'(q[1].size() + q[2].size()), 64'd0);

    @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/booth_r4_seq_mult.md
# booth_r4_seq_mult

Parametrised sequential radix-4 Booth multiplier. It retires one Booth digit per clock into a single accumulator and handles signed or unsigned operands, selected per operation. A start/ready/valid handshake connects it directly to an issuing datapath or a register-wrapped execute stage. It supersedes the fixed 32-bit, signed-only sequential multiplier, which had no handshake and used three separate 16-cycle phases.

## Interface
- WIDTH, 32, operand width; even, ≥4. Product width is 2*WIDTH.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  request; accepted on an edge where start && ready.
- signed_mode  in  1  1 = two's-complement operands, 0 = unsigned; latched at accept.
- a_in  in  WIDTH  multiplicand; latched at accept.
- b_in  in  WIDTH  multiplier; latched at accept.
- ready  out  1  high only in IDLE; start is ignored while low.
- valid  out  1  single-cycle pulse; product is final in this cycle.
- product  out  2*WIDTH  result register; holds its value until the next valid.

## Operation
- **Operand extension.** At accept, A and B are extended to EW = WIDTH+2 bits.
  - signed_mode=1: sign-extended.
  - signed_mode=0: zero-extended.
  - Digit count is D = EW/2 = WIDTH/2+1. This covers both modes and needs no per-mode correction.
- **Accumulator.** acc (2*WIDTH bits) is cleared at accept and counter k is set to 0.
- **States.**
  - IDLE: ready=1. Accept takes the FSM to RUN.
  - RUN: on each edge, take digit triplet {B[2k+1], B[2k], B[2k-1]}, with B[-1]=0.
    - Encoding: 000/111 → 0, 001/010 → +A, 011 → +2A, 100 → −2A, 101/110 → −A.
    - Form the partial product from A sign-extended to 2*WIDTH, shift it left by 2k, and add it to acc modulo 2^(2*WIDTH). Then increment k.
    - When the last digit is processed: product ← acc + pp, then go to DONE.
  - DONE: valid=1 for exactly one cycle; the next edge returns to IDLE.
- **Negation.** −A and −2A use the two's complement of extended A. A = most-negative value is exact because of the 2 guard bits.
- **Start while busy.** start while ready=0 is dropped: no queueing, no effect on the operation in flight.
- **Back-to-back.** start held high through DONE is accepted on the first IDLE cycle.
- **Reset.** rst at any point, including mid-RUN, aborts the operation and forces:
  - state=IDLE, so ready=1;
  - valid=0;
  - product=0;
  - acc=0 and k=0.
  - rst has priority over start on the same edge.

## Timing
- Accept edge E0. Digits are retired on edges E1..ED.
- product and valid are updated at ED; valid is high in the cycle after ED.
- ready returns high after E(D+1).
- Fixed latency D edges accept-to-valid; issue interval D+1 cycles. WIDTH=32 gives D=17, interval 18.
- ready is decoded from the state register (combinational). valid and product are registered.
- Outputs are stable between edges. No combinational path from inputs to outputs.

## Configuration
- **Macro: BOOTH_R4_EARLY_TERM_EN.**
- **Defined:** after retiring digit k, if extended B bits [EW-1 : 2k+1] are all equal (all 0 or all 1), every remaining digit is zero.
  - The FSM writes product and goes to DONE on that edge.
  - Latency becomes variable, minimum 1 edge.
  - The result is bit-identical to the undefined case.
- **Undefined:** the check is absent and latency is always D.
- Handshake rules are unchanged either way. The bench must use ready/valid only and never count cycles.

## Test plan
- **Signed extreme:** WIDTH=32, signed_mode=1, a=0x7FFFFFFF, b=0x80000000 → product=0xC000000080000000. Without the macro, valid comes exactly 17 edges after accept.
- **Signed and unsigned all-ones:** a=b=0xFFFFFFFF.
  - signed_mode=1 → product=0x0000000000000001.
  - signed_mode=0 → product=0xFFFFFFFE00000001.
- **Busy start ignored:** accept a=3, b=7, then pulse start with a=9, b=9 during RUN → a single valid with product=21, ready low until the interval ends. With start held, the second operation starts at the first IDLE cycle.
- **Reset mid-operation:** assert rst at edge 8 of RUN → next cycle ready=1, valid=0, product=0. A fresh a=−2, b=5 signed → 0xFFFFFFFFFFFFFFF6.
- **Early termination (macro defined):** signed_mode=0, a=5, b=3 → valid after E2, product=15. Signed b=−1 → valid after E1, product=−a.
- **Randomised check:** WIDTH=8 and WIDTH=16, random signs, modes and back-to-back starts → product matches the reference multiply. valid is never asserted twice per accept.
